// File: rtl/counter_pkg.sv
// Shared types and constants for the 1 s counter and the scheduler that time-shares it.
package counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sched_state_e;

   localparam int unsigned CLK_CYCLES_FOR_1_S = 50_000_000;

   // The counter steps through 3 values but exposes a 4-bit port.
   localparam int unsigned CNT_STEPS = 3;
   localparam int unsigned CNT_W     = 4;

endpackage

// File: rtl/counter_scheduler_arbiter.sv
// Combinational round-robin pick: searches upward from last+1 with wrap,
// returning a one-hot winner and its index.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] last_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 found_o
);

   localparam int IDX_W = $clog2(N);

   logic [IDX_W:0] cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      found_o = 1'b0;
      cand    = '0;
      for (int i = 1; i <= N; i++) begin
         cand = {1'b0, last_i} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(N)) begin
            cand = cand - (IDX_W+1)'(N);
         end
         if (!found_o && req_i[cand[IDX_W-1:0]]) begin
            found_o = 1'b1;
            idx_o   = cand[IDX_W-1:0];
         end
      end
      if (found_o) begin
         gnt_o = N'(1) << idx_o;
      end
   end

endmodule

// File: rtl/counter_scheduler.sv
// Grants the shared 1 s counter to one requester at a time and holds its
// enable for exactly the requested number of ticks.
//
//   state   | meaning
//   IDLE    | no owner; arbitrate on any req
//   RUN     | owner holds grant, counter enabled, remaining counts down
//   DONE    | done pulse out; return to IDLE next edge
module counter_scheduler
   import counter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int LEN_W   = CNT_W
) (
   input  logic                     clk_1_s,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [NUM_REQ*LEN_W-1:0] req_len_i,
   output logic [NUM_REQ-1:0]       grant_o,
   output logic [NUM_REQ-1:0]       done_o,
   output logic                     cnt_enable_o,
   output logic                     busy_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   sched_state_e       state_q, state_d;
   logic [LEN_W-1:0]   remaining_q, remaining_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               en_q, en_d;

   logic [NUM_REQ-1:0] win_gnt;
   logic [IDX_W-1:0]   win_idx;
   logic               win_found;
   logic [LEN_W-1:0]   win_len;
   logic [NUM_REQ-1:0] owner_oh;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req_i   (req_i),
      .last_i  (last_q),
      .gnt_o   (win_gnt),
      .idx_o   (win_idx),
      .found_o (win_found)
   );

   always_comb begin
      win_len = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IDX_W'(i)) begin
            win_len = req_len_i[i*LEN_W +: LEN_W];
         end
      end
   end

   // While running, last_q doubles as the owner index.
   assign owner_oh = NUM_REQ'(1) << last_q;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      last_d      = last_q;
      grant_d     = grant_q;
      done_d      = '0;
      en_d        = en_q;
      unique case (state_q)
         ST_IDLE: begin
            grant_d = '0;
            en_d    = 1'b0;
            if (win_found) begin
               last_d      = win_idx;
               remaining_d = win_len;
               if (win_len != '0) begin
                  grant_d = win_gnt;
                  en_d    = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  done_d  = win_gnt;
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (!req_i[last_q]) begin
               grant_d = '0;
               en_d    = 1'b0;
               state_d = ST_IDLE;
            end else if (remaining_q == LEN_W'(1)) begin
               grant_d = '0;
               en_d    = 1'b0;
               done_d  = owner_oh;
               state_d = ST_DONE;
            end else begin
               remaining_d = remaining_q - LEN_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = '0;
            en_d    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_1_s or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         last_q      <= IDX_W'(NUM_REQ - 1);
         grant_q     <= '0;
         done_q      <= '0;
         en_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         last_q      <= last_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         en_q        <= en_d;
      end
   end

   assign grant_o      = grant_q;
   assign done_o       = done_q;
   assign cnt_enable_o = en_q;
   assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: doc/counter_scheduler.md
# counter_scheduler

Time-shares the 1 s binary counter between several requesters. Each requester asks for a run of N counter steps. The scheduler grants one requester at a time in round-robin order and drives the counter's `enable` high for exactly N ticks of `clk_1_s`. It then pulses a per-requester `done`. The block sits between the requester logic and the counter's `enable` input, and runs in the divided 1 s clock domain.

## Interface
- `NUM_REQ`, default 2: number of requesters (2..8).
- `LEN_W`, default 4: width of each run-length field.
- `clk_1_s` in 1: divided 1 s clock, all logic on posedge.
- `reset` in 1: asynchronous, active-high; clock `clk_1_s`.
- `req` in `NUM_REQ`: level request per requester, held until its `done` or withdrawn to abort.
- `req_len` in `NUM_REQ*LEN_W`: packed run lengths; field i = `req_len[i*LEN_W +: LEN_W]`, sampled only at grant.
- `grant` out `NUM_REQ`: one-hot owner of the counter, registered.
- `done` out `NUM_REQ`: one-cycle completion pulse to the owner, registered.
- `cnt_enable` out 1: drives the counter's `enable`, registered.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- FSM states, held in a registered state variable:
  - **IDLE**: no grant, `cnt_enable` = 0.
    - If `req` = 0, stay in IDLE.
    - Otherwise pick winner w by round-robin, searching from `last+1` upward with wrap.
    - Latch `remaining` ← len(w) and set `last` ← w.
    - If len(w) ≠ 0: set `grant[w]`, set `cnt_enable`, and go to RUN.
    - If len(w) = 0: set `done[w]` and go to DONE directly. `grant` is never asserted.
  - **RUN**:
    - Each edge, `remaining` ← `remaining` − 1.
    - When `remaining` = 1: clear `cnt_enable` and `grant`, set `done[w]`, and go to DONE.
    - If `req[w]` = 0 (abort): clear `cnt_enable` and `grant`, go to IDLE, no `done` pulse.
    - Abort has priority over completion on the same edge.
  - **DONE**: clear `done`, then go to IDLE unconditionally.
- `remaining` is `LEN_W` bits unsigned. It never decrements below 1 in RUN, so there is no underflow.
- Round-robin pointer `last` resets to `NUM_REQ`−1, so requester 0 wins first after reset.
- `req_len` changes after grant are ignored.
- A requester holding `req` high through DONE is treated as a new request. It is arbitrated fairly against the others in IDLE.
- `req` bits of non-owners are ignored during RUN and DONE.

## Timing
- Reset values: state = IDLE, `grant` = 0, `done` = 0, `cnt_enable` = 0, `busy` = 0, `remaining` = 0, `last` = `NUM_REQ`−1.
- Reset mid-RUN drops `cnt_enable` immediately (asynchronously), with no `done` pulse.
- Edge E0: IDLE samples `req`.
  - From E0: `grant` and `cnt_enable` are high for exactly len cycles.
  - At E0+len: `done` rises for one cycle while `grant` and `cnt_enable` fall.
  - State returns to IDLE at E0+len+1.
  - The earliest next grant is at E0+len+2.
- Minimum gap of `cnt_enable` low between two runs is 2 cycles (DONE, IDLE).
- Abort: `req[w]` observed low at edge Ek. `cnt_enable` and `grant` fall at Ek, so the counter advances k − E0 steps.
- `done` is never high together with `cnt_enable`. At most one bit of `grant` or `done` is ever set.

## Structure
- `counter_pkg` shared package holds:
  - the state typedef (IDLE, RUN, DONE);
  - the `CLK_CYCLES_FOR_1_S` constant;
  - the counter width constant (3 steps / 4-bit port) used by the counter and the scheduler.
- Sub-module `rr_arbiter` (parameter `N`): combinational one-hot winner from `req` and `last`, plus a winner index.
  - The scheduler registers `last` and the FSM.

## Test plan
- Reset, then `req[0]`=1 with len0=3 → `grant` = 2'b01 and `cnt_enable` high for 3 cycles, `done` = 2'b01 for one cycle on the 4th, `busy` low 2 cycles after grant ends.
- `req` = 2'b11 held continuously, len0=2, len1=1 → grants alternate 0,1,0,1. Enable patterns: 2 high, 2 low, 1 high, 2 low, repeating.
- len1 = 0 with `req` = 2'b10 → `done` = 2'b10 one cycle after the sampling edge, `grant` and `cnt_enable` never high.
- len0=15, deassert `req[0]` after 4 enable cycles → `cnt_enable` falls at that edge, no `done` pulse, IDLE next.
- Assert `reset` mid-RUN with len=8 at cycle 3 → all outputs 0 immediately. After release, requester 0 has first priority again.
- `NUM_REQ`=4, LEN_W=4, all `req` high, len=1 each → grant order 0,1,2,3,0, with the `done` one-hot matching each grant.
